// File: rtl/ad80305_if_pkg.sv
// ad80305_if_pkg: shared constants, state encoding and saturation helper for the AD80305 data interfaces
package ad80305_if_pkg;
  localparam int ADC_W = 12;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_RUN     = 2'd2
  } tx_state_e;
  localparam logic FRAME_I = 1'b1;
  localparam logic FRAME_Q = 1'b0;
  function automatic logic [ADC_W-1:0] sat12(input logic [ADC_W:0] v);
    return (v[ADC_W] != v[ADC_W-1]) ? {v[ADC_W], {(ADC_W-1){~v[ADC_W]}}} : v[ADC_W-1:0];
  endfunction
endpackage

// File: rtl/ad80305_tx_fifo.sv
// ad80305_tx_fifo: single-clock FIFO with flush and saturating occupancy count
module ad80305_tx_fifo #(
  parameter int W  = 24,
  parameter int AW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);
  localparam int DEPTH = 2**AW;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] lvl_q;
  logic do_push, do_pop;
  assign full_o  = lvl_q == (AW+1)'(DEPTH);
  assign empty_o = lvl_q == '0;
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rp_q];
  assign level_o = lvl_q;
  // Storage array; a slot is only read after it has been written
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end
  // Pointers wrap naturally; flush discards everything like a reset
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(do_push);
      rp_q  <= rp_q + AW'(do_pop);
      lvl_q <= lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ad80305_tx_if_ddr_lvcmos.sv
// ad80305_tx_if_ddr_lvcmos: rounds I/Q to 12 bits, buffers them and drives framed DDR halves for the ODDR
module ad80305_tx_if_ddr_lvcmos
  import ad80305_if_pkg::*;
#(
  parameter int IN_W        = 16,
  parameter int FIFO_AW     = 3,
  parameter int PREFILL_LVL = 4,
  parameter int FRAME_ON_H  = 1
) (
  input  logic               i_fpga_clk_125p,
  input  logic               i_fpga_rst_125p,
  input  logic               i_tx_en,
  input  logic               i_iq_valid,
  output logic               o_iq_ready,
  input  logic [IN_W-1:0]    i_idata,
  input  logic [IN_W-1:0]    i_qdata,
  output logic [ADC_W:0]     o_dataout_h,
  output logic [ADC_W:0]     o_dataout_l,
  output logic               o_underflow,
  input  logic               i_underflow_clr,
  output logic [FIFO_AW:0]   o_fifo_level,
  output logic [1:0]         o_state
);
  localparam int DEPTH = 2**FIFO_AW;
  localparam int D = IN_W - ADC_W;
  localparam logic [IN_W:0] HALF = ((IN_W+1)'(1) << D) >> 1;
  function automatic logic [ADC_W-1:0] rnd(input logic [IN_W-1:0] x);
    logic [IN_W:0] s;
    s = {x[IN_W-1], x} + HALF;
    return sat12(s[IN_W -: ADC_W+1]);
  endfunction
  tx_state_e state_q, state_d;
  logic wr_q;
  logic [2*ADC_W-1:0] wr_data_q, rd_data;
  logic full, empty, pop, uf_set, uf_q;
  logic [FIFO_AW:0] level;
  logic [ADC_W:0] i_word, q_word, out_h_d, out_l_d, out_h_q, out_l_q;
  // The in-flight rounded word counts against capacity so it always finds room
  assign o_iq_ready = i_tx_en && !full && !(wr_q && level == (FIFO_AW+1)'(DEPTH-1));
  // Round on acceptance; wr_q marks a word that enters the FIFO next edge
  always_ff @(posedge i_fpga_clk_125p) begin
    if (i_fpga_rst_125p) begin
      wr_q      <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_q      <= i_iq_valid && o_iq_ready;
      wr_data_q <= {rnd(i_qdata), rnd(i_idata)};
    end
  end
  ad80305_tx_fifo #(.W(2*ADC_W), .AW(FIFO_AW)) u_fifo (
    .clk_i   (i_fpga_clk_125p),
    .rst_i   (i_fpga_rst_125p),
    .flush_i (!i_tx_en),
    .push_i  (wr_q),
    .pop_i   (pop),
    .din_i   (wr_data_q),
    .dout_o  (rd_data),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );
  // State register
  always_ff @(posedge i_fpga_clk_125p) begin
    state_q <= i_fpga_rst_125p ? ST_IDLE : state_d;
  end
  // Enable gates everything; prefill waits for the threshold, RUN holds even when starved
  always_comb begin
    state_d = !i_tx_en ? ST_IDLE :
              state_q == ST_IDLE ? ST_PREFILL :
              (state_q == ST_PREFILL && level >= (FIFO_AW+1)'(PREFILL_LVL)) ? ST_RUN : state_q;
  end
  // Pop and framed output words from the current state; empty RUN sends frame-only zeros
  always_comb begin
    pop     = state_q == ST_RUN && !empty;
    uf_set  = state_q == ST_RUN && empty;
    i_word  = {FRAME_I, rd_data[ADC_W-1:0] & {ADC_W{pop}}};
    q_word  = {FRAME_Q, rd_data[2*ADC_W-1:ADC_W] & {ADC_W{pop}}};
    out_h_d = state_q == ST_IDLE ? '0 : (FRAME_ON_H != 0 ? i_word : q_word);
    out_l_d = state_q == ST_IDLE ? '0 : (FRAME_ON_H != 0 ? q_word : i_word);
  end
  // Output registers and sticky underflow, where a new underflow beats a clear
  always_ff @(posedge i_fpga_clk_125p) begin
    if (i_fpga_rst_125p) begin
      out_h_q <= '0;
      out_l_q <= '0;
      uf_q    <= 1'b0;
    end else begin
      out_h_q <= out_h_d;
      out_l_q <= out_l_d;
      uf_q    <= uf_set || (uf_q && !i_underflow_clr);
    end
  end
  assign o_dataout_h  = out_h_q;
  assign o_dataout_l  = out_l_q;
  assign o_underflow  = uf_q;
  assign o_fifo_level = level;
  assign o_state      = state_q;
endmodule
